// File: rtl/class_route_arbiter.sv
// Pop-side arbiter: picks one class FIFO per cycle (class 0 priority with weighted
// anti-starvation for class 1) and routes the popped payload to a route FIFO.
module class_route_arbiter #(
  parameter int DATA_SIZE = 10,
  parameter int MAIN_SIZE = 8,
  parameter int WEIGHT    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo0_empty,
  input  logic                 fifo1_empty,
  input  logic [DATA_SIZE-1:0] in0,
  input  logic [DATA_SIZE-1:0] in1,
  input  logic                 pause,
  input  logic                 almost_full0,
  input  logic                 almost_full1,
  input  logic                 fifo_full0,
  input  logic                 fifo_full1,
  output logic                 pop0,
  output logic                 pop1,
  output logic                 push0,
  output logic                 push1,
  output logic [MAIN_SIZE-1:0] data_out,
  output logic                 busy,
  output logic                 Error
);

  localparam logic [3:0] WEIGHT_CNT = 4'(WEIGHT);

  logic                 issue;
  logic                 grant1;
  logic [3:0]           starve_cnt;
  logic                 s1_valid;
  logic                 s1_src;
  logic [DATA_SIZE-1:0] s1_word;
  logic                 s2_valid;
  logic                 s2_dest;
  logic [MAIN_SIZE-1:0] s2_payload;
  logic [MAIN_SIZE-1:0] last_data;
  logic                 drop;
  logic                 err;
  logic                 unused_msb;

  always_comb begin
    issue      = !reset && !pause && !almost_full0 && !almost_full1 &&
                 (!fifo0_empty || !fifo1_empty);
    grant1     = fifo0_empty || (!fifo1_empty && starve_cnt == WEIGHT_CNT);
    pop0       = issue && !grant1;
    pop1       = issue && grant1;
    s1_word    = s1_src ? in1 : in0;
    unused_msb = s1_word[DATA_SIZE-1];
    push0      = s2_valid && !s2_dest && !fifo_full0;
    push1      = s2_valid && s2_dest && !fifo_full1;
    drop       = s2_valid && (s2_dest ? fifo_full1 : fifo_full0);
    // Bus shows the pushing payload, otherwise the last payload actually pushed.
    data_out   = (push0 || push1) ? s2_payload : last_data;
    busy       = s1_valid || s2_valid;
    Error      = err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      s1_valid   <= 1'b0;
      s1_src     <= 1'b0;
      s2_valid   <= 1'b0;
      s2_dest    <= 1'b0;
      s2_payload <= '0;
      last_data  <= '0;
      err        <= 1'b0;
    end else begin
      s1_valid <= issue;
      s1_src   <= grant1;
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_dest    <= s1_word[DATA_SIZE-2];
        s2_payload <= s1_word[DATA_SIZE-3:0];
      end
      if (push0 || push1)
        last_data <= s2_payload;
      if (drop)
        err <= 1'b1;
      if (fifo1_empty || pop1)
        starve_cnt <= '0;
      else if (pop0 && starve_cnt != WEIGHT_CNT)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_class_route_arbiter.sv
// Bench for class_route_arbiter: directed table, hand sequences and random
// stimulus checked against a queue-based reference model.
module tb_class_route_arbiter;

  localparam int DATA_SIZE = 10;
  localparam int MAIN_SIZE = 8;
  localparam int WEIGHT    = 4;

  logic                 clk = 1'b0;
  logic                 reset, fifo0_empty, fifo1_empty, pause;
  logic                 almost_full0, almost_full1, fifo_full0, fifo_full1;
  logic [DATA_SIZE-1:0] in0, in1;
  logic                 pop0, pop1, push0, push1, busy, Error;
  logic [MAIN_SIZE-1:0] data_out;

  class_route_arbiter #(.DATA_SIZE(DATA_SIZE), .MAIN_SIZE(MAIN_SIZE), .WEIGHT(WEIGHT)) dut (
    .clk(clk), .reset(reset), .fifo0_empty(fifo0_empty), .fifo1_empty(fifo1_empty),
    .in0(in0), .in1(in1), .pause(pause), .almost_full0(almost_full0),
    .almost_full1(almost_full1), .fifo_full0(fifo_full0), .fifo_full1(fifo_full1),
    .pop0(pop0), .pop1(pop1), .push0(push0), .push1(push1), .data_out(data_out),
    .busy(busy), .Error(Error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, pa, e0, e1, af0, af1, f0, f1;
    bit p0, p1, u0, u1;
    logic [7:0] dout;
    bit bsy, err;
  } row_t;

  typedef struct {
    int         age;
    bit         src;
    logic [9:0] word;
  } flight_t;

  int checks = 0;
  int errors = 0;

  // reference model state
  flight_t    q[$];
  int         run0 = 0;
  bit         m_err = 0;
  logic [7:0] m_last = '0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic drive(input bit rst, pa, e0, e1, af0, af1, f0, f1,
                       input logic [9:0] i0, i1);
    reset = rst; pause = pa; fifo0_empty = e0; fifo1_empty = e1;
    almost_full0 = af0; almost_full1 = af1; fifo_full0 = f0; fifo_full1 = f1;
    in0 = i0; in1 = i1;
    #4;
  endtask

  // compare DUT against the model for the current (already driven) cycle
  task automatic model_check();
    bit issue, g, ep0, ep1, eu0, eu1;
    logic [7:0] ed;
    issue = !reset && !pause && !almost_full0 && !almost_full1 &&
            (!fifo0_empty || !fifo1_empty);
    if (fifo0_empty) g = 1;
    else if (fifo1_empty) g = 0;
    else g = (run0 >= WEIGHT);
    ep0 = issue && !g;
    ep1 = issue && g;
    eu0 = 0; eu1 = 0; ed = m_last;
    foreach (q[i]) if (q[i].age == 2) begin
      if (q[i].word[8]) eu1 = !fifo_full1; else eu0 = !fifo_full0;
      if (eu0 || eu1) ed = q[i].word[7:0];
    end
    chk("m_pop0", pop0, ep0);
    chk("m_pop1", pop1, ep1);
    chk("m_push0", push0, eu0);
    chk("m_push1", push1, eu1);
    chk("m_data", data_out, ed);
    chk("m_busy", busy, q.size() > 0);
    chk("m_error", Error, m_err);
  endtask

  // advance the model across the coming edge, then move past it
  task automatic tick();
    bit issue, g;
    flight_t nq[$];
    issue = !reset && !pause && !almost_full0 && !almost_full1 &&
            (!fifo0_empty || !fifo1_empty);
    if (fifo0_empty) g = 1;
    else if (fifo1_empty) g = 0;
    else g = (run0 >= WEIGHT);
    if (reset) begin
      q.delete(); run0 = 0; m_err = 0; m_last = '0;
    end else begin
      foreach (q[i]) begin
        if (q[i].age == 2) begin
          if (q[i].word[8] ? fifo_full1 : fifo_full0) m_err = 1;
          else m_last = q[i].word[7:0];
        end else begin
          flight_t f = q[i];
          f.word = f.src ? in1 : in0;
          f.age = 2;
          nq.push_back(f);
        end
      end
      if (issue) nq.push_back('{age: 1, src: g, word: '0});
      q = nq;
      if (fifo1_empty || (issue && g)) run0 = 0;
      else if (issue) run0 = (run0 + 1 > WEIGHT) ? WEIGHT : run0 + 1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic row_t mk(bit rst, pa, e0, e1, af0, af1, f0, f1,
                              bit p0, p1, u0, u1, logic [7:0] d, bit b, bit er);
    row_t r;
    r.rst = rst; r.pa = pa; r.e0 = e0; r.e1 = e1; r.af0 = af0; r.af1 = af1;
    r.f0 = f0; r.f1 = f1; r.p0 = p0; r.p1 = p1; r.u0 = u0; r.u1 = u1;
    r.dout = d; r.bsy = b; r.err = er;
    return r;
  endfunction

  row_t tbl[$];
  logic [9:0] w0, w1;

  initial begin
    w0 = 10'b01_1010_0101;  // dest 1, payload A5
    w1 = 10'b00_0011_1100;  // dest 0, payload 3C
    //            rst pa e0 e1 af0 af1 f0 f1 | p0 p1 u0 u1 data  busy err
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 8'hA5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 8'hA5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 8'hA5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 8'hA5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 8'h3C, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 8'hA5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 8'hA5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 8'hA5, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 1, 8'hA5, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 1, 0, 8'h3C, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 8'h3C, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 8'h3C, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 8'h3C, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 8'h3C, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 8'h3C, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0,   0, 0, 0, 0, 8'h3C, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 1, 8'hA5, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 8'hA5, 0, 1));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 8'hA5, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 8'h00, 0, 0));

    // first edge under reset brings the DUT out of X; not compared
    drive(1, 0, 0, 0, 0, 0, 0, 0, w0, w1);
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].pa, tbl[i].e0, tbl[i].e1, tbl[i].af0, tbl[i].af1,
            tbl[i].f0, tbl[i].f1, w0, w1);
      chk($sformatf("t%0d_pop0", i), pop0, tbl[i].p0);
      chk($sformatf("t%0d_pop1", i), pop1, tbl[i].p1);
      chk($sformatf("t%0d_push0", i), push0, tbl[i].u0);
      chk($sformatf("t%0d_push1", i), push1, tbl[i].u1);
      chk($sformatf("t%0d_data", i), data_out, tbl[i].dout);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("t%0d_err", i), Error, tbl[i].err);
      model_check();
      tick();
    end

    // back-pressure: two pops, then almost_full1 for 5 cycles
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 0, 0, 0, 0, w0, w1);
      chk("bp_prepop", pop0, 1);
      model_check();
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0, 0, w0, w1);
      chk("bp_nopop", pop0 | pop1, 0);
      chk("bp_drain", push1, i < 2);
      model_check();
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, w0, w1);
    chk("bp_resume", pop0, 1);
    model_check();
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 0, 0, 0, 0, w0, w1);
      model_check();
      tick();
    end

    // reset the cycle after a pop1 of a dest-1 word
    drive(0, 0, 1, 0, 0, 0, 0, 0, w0, 10'b01_1100_0011);
    chk("rm_pop1", pop1, 1);
    model_check();
    tick();
    drive(1, 0, 1, 1, 0, 0, 0, 0, w0, 10'b01_1100_0011);
    chk("rm_busy_before", busy, 1);
    model_check();
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 0, 0, 0, 0, w0, 10'b01_1100_0011);
      chk("rm_nopush", push1, 0);
      chk("rm_idle", busy, 0);
      model_check();
      tick();
    end

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(63) == 0, $urandom_range(7) == 0,
            $urandom_range(3) == 0, $urandom_range(3) == 0,
            $urandom_range(9) == 0, $urandom_range(9) == 0,
            $urandom_range(15) == 0, $urandom_range(15) == 0,
            10'($urandom), 10'($urandom));
      model_check();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/class_route_arbiter.md
# class_route_arbiter

Pop-side arbiter between the two class FIFOs and the two route FIFOs of the adaptive PCIe switching device. Each cycle it picks at most one class FIFO to pop (class 0 priority, with a weighted anti-starvation rule for class 1). It captures the popped word and pushes its payload into the route FIFO selected by the word's destination bit. Downstream back-pressure comes from the route FIFOs' almost-full and full flags.

## Interface
- DATA_SIZE, 10, class-FIFO word width; bit [DATA_SIZE-2] = destination, bits [DATA_SIZE-3:0] = payload
- MAIN_SIZE, 8, payload width; must equal DATA_SIZE-2
- WEIGHT, 4, max consecutive class-0 grants while class 1 waits; legal range 1..15

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- fifo0_empty / fifo1_empty  in  1  class FIFO 0/1 empty flags
- in0 / in1  in  DATA_SIZE  class FIFO 0/1 read data, valid the cycle after the pop
- pause  in  1  global hold; no new pops while high
- almost_full0 / almost_full1  in  1  route FIFO 0/1 almost-full; threshold leaves at least 2 free entries
- fifo_full0 / fifo_full1  in  1  route FIFO 0/1 full
- pop0 / pop1  out  1  pop strobes to class FIFO 0/1
- push0 / push1  out  1  push strobes to route FIFO 0/1
- data_out  out  MAIN_SIZE  payload to the route FIFOs; shared bus, qualified by push0/push1
- busy  out  1  any word in flight (stage 1 or stage 2 valid)
- Error  out  1  sticky overflow flag

## Operation
- Issue condition (comb, cycle t): !reset && !pause && !almost_full0 && !almost_full1 && at least one class FIFO non-empty.
- Grant selection:
  - Only FIFO 0 non-empty: grant 0.
  - Only FIFO 1 non-empty: grant 1.
  - Both non-empty: grant 0 unless starve_cnt == WEIGHT, then grant 1.
- At most one of pop0/pop1 per cycle. Never pop an empty FIFO.
- starve_cnt (4-bit):
  - +1 on each grant 0 while fifo1_empty == 0.
  - Cleared on grant 1 or whenever fifo1_empty == 1.
  - Saturates at WEIGHT.
- Pipeline:
  - Stage 1 (s1_valid, s1_src) registers the grant.
  - During t+1, in[s1_src] is sampled into stage 2 (s2_valid, s2_dest = bit DATA_SIZE-2, s2_payload = bits DATA_SIZE-3:0).
  - Stage 2 drives its outputs during t+2.
- Push, registered outputs in cycle t+2: push{s2_dest}=1 and data_out=s2_payload, unless fifo_full{s2_dest}=1. In that case the push is suppressed, the word is dropped and Error is set.
- Error stays high until reset.
- pause or almost_full does not flush in-flight words; stages 1/2 always drain.
- Throughput: one word per cycle sustained.

## Timing
- Reset values: pop0=pop1=push0=push1=0, data_out=0, busy=0, Error=0, starve_cnt=0, s1_valid=s2_valid=0.
- pop is combinational from registered state and inputs in cycle t. The corresponding push is registered and appears in cycle t+2. Latency is 2 cycles.
- data_out holds its last value when no push is active.
- Reset asserted mid-operation: the next edge clears all state. In-flight words are discarded; no push follows.
- almost_full deasserting at t gives a pop at t if other conditions hold.
- Two words can be in flight when almost_full rises. The required 2-entry margin makes overflow impossible with compliant FIFOs.
- Simultaneous pause and grant: pause wins; no pop.
- fifo empty flags are sampled in the same cycle as the pop decision; no look-ahead.

## Test plan
- Reset: hold reset 2 cycles with both FIFOs non-empty -> all outputs 0, no pop. After release, first pop0 at the next cycle.
- Priority/starvation, WEIGHT=4, both FIFOs non-empty continuously -> pop pattern 0,0,0,0,1,0,0,0,0,1.
- Routing: FIFO 0 word 10'b01_10100101 popped at t -> push1=1, data_out=8'hA5 at t+2, push0=0.
- Back-pressure: almost_full1=1 for 5 cycles with data pending -> no pop for those 5 cycles. Pops resume the cycle after it drops; in-flight words still pushed.
- Overflow: fifo_full0=1 in the cycle a dest-0 word reaches stage 2 -> push0=0, Error=1 from the next cycle, stays 1 until reset.
- Reset mid-flight: assert reset the cycle after pop1 -> no push1 ever appears, busy=0 after that edge.
